// File: rtl/spi_adc_reader_if.sv
// Sample handshake between the ADC reader and its consumer (valid/ready plus drop flag).
interface spi_adc_reader_if #(
  parameter int operand_size = 12
) ();
  logic [operand_size-1:0] sample_out;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    overrun;

  modport master (output sample_out, output sample_valid, output overrun, input sample_ready);
  modport slave  (input sample_out, input sample_valid, input overrun, output sample_ready);
endinterface

// File: rtl/spi_adc_reader.sv
// SPI ADC front end (CPOL=0): one frame per conversion, sample registered 1 cycle after frame end.
// Backpressure: one-deep output register; a frame completing while it is still full is dropped with an overrun pulse.
module spi_adc_reader #(
  parameter int operand_size  = 12,
  parameter int lead_bits     = 4,
  parameter int clk_div       = 4,
  parameter int gap_cycles    = 8,
  parameter bit offset_binary = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             adc_miso,
  output logic             adc_sclk,
  output logic             adc_cs_n,
  spi_adc_reader_if.master smp
);
  localparam int frame_bits = lead_bits + operand_size;
  localparam int cnt_max    = (clk_div > gap_cycles) ? clk_div : gap_cycles;
  localparam int cnt_w      = $clog2(cnt_max + 1);
  localparam int bit_w      = $clog2(frame_bits + 1);
  localparam logic [cnt_w-1:0]        div_last  = cnt_w'(clk_div - 1);
  localparam logic [cnt_w-1:0]        gap_last  = cnt_w'(gap_cycles - 1);
  localparam logic [bit_w-1:0]        bits_all  = bit_w'(frame_bits);
  localparam logic [operand_size-1:0] msb_flip  = {offset_binary, {(operand_size-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t                  state, state_nxt;
  logic [cnt_w-1:0]        cnt, cnt_nxt;
  logic [bit_w-1:0]        bit_cnt, bit_cnt_nxt;
  logic                    sclk_nxt, cs_n_nxt;
  logic                    shift_en, frame_done;
  logic [operand_size-1:0] shreg, sample, sample_q;
  logic                    valid_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      adc_sclk <= 1'b0;
      adc_cs_n <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      adc_sclk <= sclk_nxt;
      adc_cs_n <= cs_n_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sclk_nxt    = adc_sclk;
    cs_n_nxt    = adc_cs_n;
    shift_en    = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
        if (enable) begin
          state_nxt = START;
          cs_n_nxt  = 1'b0;
        end
      end
      START: begin
        if (cnt == div_last) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == div_last) begin
          cnt_nxt  = '0;
          sclk_nxt = ~adc_sclk;
          if (!adc_sclk) begin
            // rising SCLK edge: the ADC's bit has been stable for a full half-period
            shift_en    = 1'b1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else if (bit_cnt == bits_all) begin
            state_nxt = STOP;
            cs_n_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        frame_done = (cnt == '0);
        if (cnt == gap_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lead bits shift straight through and fall off the top of the register.
  assign sample = shreg ^ msb_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (shift_en) shreg <= {shreg[operand_size-2:0], adc_miso};
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!valid_q || smp.sample_ready) begin
          sample_q <= sample;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && smp.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign smp.sample_out   = sample_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;
endmodule
